// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo register-status logic.
package tomasulo_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned TAGW = 6;
  localparam int unsigned NRS  = 16;

  typedef logic [REGW-1:0] regidx_t;
  typedef logic [TAGW-1:0] tag_t;

  // Tags 0..15 name RS slots; READY_TAG means "value lives in the register file".
  localparam tag_t RS_TAG_MAX = tag_t'(NRS - 1);
  localparam tag_t READY_TAG  = 6'd16;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } rs_state_e;

  function automatic logic tag_legal(input tag_t t);
    return (t <= RS_TAG_MAX) || (t == READY_TAG);
  endfunction

endpackage

// File: rtl/regstatus_lookup.sv
// One source-operand lookup port into the register-status table, with CDB bypass.
module regstatus_lookup
  import tomasulo_pkg::*;
#(
  parameter bit ZERO_RO = 1'b1
) (
  input  tag_t [NREG-1:0] i_table,
  input  regidx_t         i_rs,
  input  logic            i_cdb_valid,
  input  tag_t            i_cdb_tag,
  output tag_t            o_q
);

  tag_t w_entry;

  // Select the entry, then override with READY when r0 or the producer completes now.
  always_comb begin
    w_entry = i_table[i_rs];
    o_q     = w_entry;
    if (ZERO_RO && (i_rs == '0)) begin
      o_q = READY_TAG;
    end else if (i_cdb_valid && (w_entry == i_cdb_tag)) begin
      o_q = READY_TAG;
    end
  end

endmodule

// File: rtl/regstatus_ctrl.sv
// Register-status table owner: rename, CDB wakeup, dual lookup and flush walk.
module regstatus_ctrl
  import tomasulo_pkg::*;
#(
  parameter bit ZERO_RO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [REGW-1:0] iss_rd,
  input  logic [TAGW-1:0] iss_tag,
  input  logic [REGW-1:0] iss_rs1,
  input  logic [REGW-1:0] iss_rs2,
  output logic [TAGW-1:0] q1,
  output logic [TAGW-1:0] q2,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic            flush_req,
  output logic            flush_busy
);

  tag_t [NREG-1:0] r_table;
  tag_t [NREG-1:0] w_table_d;
  rs_state_e       r_state;
  rs_state_e       w_state_d;
  regidx_t         r_idx;
  regidx_t         w_idx_d;
  logic            w_rename;

  // A flush request in the same cycle beats a rename.
  assign iss_ready  = (r_state == StIdle) && !flush_req;
  assign flush_busy = (r_state == StFlush);
  // r0 renames complete the handshake but never touch the table.
  assign w_rename   = iss_valid && iss_ready && !(ZERO_RO && (iss_rd == '0));

  // Flush walk sequencing: one entry per cycle, re-requests ignored while walking.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (flush_req) begin
          w_state_d = StFlush;
          w_idx_d   = '0;
        end
      end
      StFlush: begin
        w_idx_d = r_idx + 1'b1;
        if (r_idx == regidx_t'(NREG - 1)) begin
          w_state_d = StIdle;
        end
      end
    endcase
  end

  // Per-entry next value; later assignments take priority (rename is the newest producer).
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_table_d[i] = r_table[i];
      if (cdb_valid && (cdb_tag != READY_TAG) && (r_table[i] == cdb_tag)) begin
        w_table_d[i] = READY_TAG;
      end
      if ((r_state == StFlush) && (r_idx == regidx_t'(i))) begin
        w_table_d[i] = READY_TAG;
      end
      if (w_rename && (iss_rd == regidx_t'(i))) begin
        w_table_d[i] = iss_tag;
      end
    end
  end

  // State, walk index and table registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_table <= {NREG{READY_TAG}};
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_table <= w_table_d;
    end
  end

  // Only RS slot tags or READY may be written by a committed rename.
  always_ff @(posedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      assert (tag_legal(iss_tag));
    end
  end

  regstatus_lookup #(
    .ZERO_RO(ZERO_RO)
  ) u_lookup_rs1 (
    .i_table    (r_table),
    .i_rs       (iss_rs1),
    .i_cdb_valid(cdb_valid),
    .i_cdb_tag  (cdb_tag),
    .o_q        (q1)
  );

  regstatus_lookup #(
    .ZERO_RO(ZERO_RO)
  ) u_lookup_rs2 (
    .i_table    (r_table),
    .i_rs       (iss_rs2),
    .i_cdb_valid(cdb_valid),
    .i_cdb_tag  (cdb_tag),
    .o_q        (q2)
  );

endmodule

// File: tb/tb_regstatus_ctrl.sv
// Bench for regstatus_ctrl: directed scenarios plus random traffic against a table model.
module tb_regstatus_ctrl;

  logic       clk;
  logic       rst;
  logic       iss_valid;
  logic       iss_ready;
  logic [4:0] iss_rd;
  logic [5:0] iss_tag;
  logic [4:0] iss_rs1;
  logic [4:0] iss_rs2;
  logic [5:0] q1;
  logic [5:0] q2;
  logic       cdb_valid;
  logic [5:0] cdb_tag;
  logic       flush_req;
  logic       flush_busy;

  int n_cmp;
  int n_fail;

  // Reference model: register -> pending producer (16 = ready), plus flush cycles remaining.
  int m_tbl [32];
  int m_flush_left;

  regstatus_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_rd    (iss_rd),
    .iss_tag   (iss_tag),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .q1        (q1),
    .q2        (q2),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .flush_req (flush_req),
    .flush_busy(flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) m_tbl[r] = 16;
    m_flush_left = 0;
  endfunction

  function automatic bit m_ready();
    return (m_flush_left == 0) && !flush_req;
  endfunction

  function automatic int m_lookup(input logic [4:0] rs);
    if (rs == 5'd0) return 16;
    if (cdb_valid && (m_tbl[rs] == int'(cdb_tag))) return 16;
    return m_tbl[rs];
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  function automatic void m_step();
    int nt [32];
    bit commit;
    if (rst) begin
      m_reset();
      return;
    end
    commit = iss_valid && m_ready();
    nt = m_tbl;
    for (int r = 0; r < 32; r++) begin
      if (cdb_valid && (cdb_tag != 6'd16) && (m_tbl[r] == int'(cdb_tag))) nt[r] = 16;
    end
    if (m_flush_left > 0) nt[32 - m_flush_left] = 16;
    if (commit && (iss_rd != 5'd0)) nt[iss_rd] = int'(iss_tag);
    if (m_flush_left > 0) m_flush_left--;
    else if (flush_req) m_flush_left = 32;
    m_tbl = nt;
  endfunction

  task automatic idle();
    iss_valid = 1'b0;
    cdb_valid = 1'b0;
    flush_req = 1'b0;
    iss_rd    = 5'd0;
    iss_tag   = 6'd0;
    cdb_tag   = 6'd0;
  endtask

  // Compare combinational outputs mid-cycle against the model.
  task automatic sample();
    @(negedge clk);
    check("q1", q1, 6'(m_lookup(iss_rs1)));
    check("q2", q2, 6'(m_lookup(iss_rs2)));
    check_bit("iss_ready", iss_ready, m_ready());
    check_bit("flush_busy", flush_busy, m_flush_left > 0);
  endtask

  task automatic advance();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic sweep(input bit all_ready);
    for (int k = 0; k < 16; k++) begin
      iss_rs1 = 5'(2 * k);
      iss_rs2 = 5'(2 * k + 1);
      sample();
      if (all_ready) begin
        check("sweep_q1", q1, 6'd16);
        check("sweep_q2", q2, 6'd16);
      end
      advance();
    end
  endtask

  initial begin
    int cnt;
    n_cmp  = 0;
    n_fail = 0;
    idle();
    iss_rs1 = 5'd0;
    iss_rs2 = 5'd0;
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset contents
    sample();
    check_bit("reset_ready", iss_ready, 1'b1);
    check_bit("reset_busy", flush_busy, 1'b0);
    advance();
    sweep(1'b1);

    // Rename r5 <- 3, lookup, bypass, cleared
    iss_valid = 1'b1; iss_rd = 5'd5; iss_tag = 6'd3;
    cyc();
    idle(); iss_rs1 = 5'd5;
    sample(); check("r5_tag3", q1, 6'd3); advance();
    cdb_valid = 1'b1; cdb_tag = 6'd3;
    sample(); check("r5_bypass", q1, 6'd16); advance();
    idle();
    sample(); check("r5_cleared", q1, 6'd16); advance();

    // Two registers waiting on one tag
    iss_valid = 1'b1; iss_tag = 6'd3; iss_rd = 5'd7; cyc();
    iss_rd = 5'd9; cyc();
    idle(); iss_rs1 = 5'd7; iss_rs2 = 5'd9;
    sample(); check("r7_pending", q1, 6'd3); check("r9_pending", q2, 6'd3); advance();
    cdb_valid = 1'b1; cdb_tag = 6'd3;
    sample(); check("r7_bypass", q1, 6'd16); check("r9_bypass", q2, 6'd16); advance();

    // Rename wins over a same-edge CDB clear
    idle(); iss_valid = 1'b1; iss_tag = 6'd3; iss_rd = 5'd7; cyc();
    iss_rd = 5'd9; cyc();
    iss_rd = 5'd7; iss_tag = 6'd4; cdb_valid = 1'b1; cdb_tag = 6'd3; cyc();
    idle();
    sample(); check("r7_rename_wins", q1, 6'd4); check("r9_cdb_cleared", q2, 6'd16); advance();

    // r0 is read-only
    iss_valid = 1'b1; iss_rd = 5'd0; iss_tag = 6'd2;
    sample(); check_bit("r0_handshake", iss_ready, 1'b1); advance();
    idle(); iss_rs1 = 5'd0;
    sample(); check("r0_ready", q1, 6'd16); advance();

    // Full flush with every register pending and issue attempts during the walk
    for (int i = 1; i < 32; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(i); iss_tag = 6'(i % 16);
      cyc();
    end
    idle(); iss_valid = 1'b1; iss_rd = 5'd4; iss_tag = 6'd1; flush_req = 1'b1;
    sample(); check_bit("flush_beats_rename", iss_ready, 1'b0); advance();
    idle();
    for (int c = 0; c < 32; c++) begin
      iss_valid = 1'b1;
      iss_rd = 5'($urandom_range(1, 31));
      iss_tag = 6'($urandom_range(0, 15));
      iss_rs1 = 5'($urandom_range(0, 31));
      iss_rs2 = 5'($urandom_range(0, 31));
      sample();
      check_bit("walk_busy", flush_busy, 1'b1);
      check_bit("walk_ready", iss_ready, 1'b0);
      advance();
    end
    idle();
    sample(); check_bit("walk_done", flush_busy, 1'b0); advance();
    sweep(1'b1);

    // Second flush_req mid-walk does not extend the walk
    for (int i = 3; i < 7; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(i); iss_tag = 6'(i); cyc();
    end
    idle(); flush_req = 1'b1; cyc();
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      flush_req = (c == 5);
      sample();
      if (!flush_busy) break;
      cnt++;
      advance();
    end
    idle(); advance();
    check("walk_length", 6'(cnt), 6'd32);
    sweep(1'b1);

    // Reset at walk index 10
    for (int i = 10; i < 20; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(i); iss_tag = 6'(i - 5); cyc();
    end
    idle(); flush_req = 1'b1; cyc();
    idle();
    for (int c = 0; c < 10; c++) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    sample();
    check_bit("rst_busy", flush_busy, 1'b0);
    check_bit("rst_ready", iss_ready, 1'b1);
    advance();
    sweep(1'b1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 31));
      iss_tag   = 6'($urandom_range(0, 16));
      iss_rs1   = 5'($urandom_range(0, 31));
      iss_rs2   = 5'($urandom_range(0, 31));
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = 6'($urandom_range(0, 16));
      flush_req = ($urandom_range(0, 39) == 0);
      cyc();
    end
    idle();
    sweep(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
